cp0_unit: RTL
=============

// Module: cp0_unit
// PURPOSE
//  Coprocessor-0 responder for the fetch unit's exception interface: holds SR, Cause, EPC, PRId.
//  Sits beside M stage; samples ExcCode/BD/PC, raises Req to flush pipe and redirect fetch to handler.
//  Supplies EPC to fetch for eret; serves mfc0 reads and mtc0 writes.
// PARAMETERS
//  PRID_VALUE   32'h2021_0007   read-only value of PRId (reg 15)
//  HWINT_W      6               hardware interrupt lines; map to Cause.IP / SR.IM [15:10]
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-low; sampled on clk rising edge
//  a1         in   5   CP0 register number for mfc0 read
//  a2         in   5   CP0 register number for mtc0 write
//  din        in   32  mtc0 write data
//  we         in   1   mtc0 write enable (M stage)
//  vpc        in   32  PC of M-stage instruction (victim PC)
//  bd_in      in   1   M-stage instruction is in a delay slot
//  exc_in     in   5   M-stage ExcCode; 0 = no exception
//  exl_clr    in   1   eret committing; clears SR.EXL
//  hwint      in   6   external interrupt lines, level-sensitive
//  req        out  1   take exception/interrupt this cycle (flush + fetch redirect to 0x4180)
//  epc_out    out  32  current EPC register, to fetch for eret
//  dout       out  32  mfc0 read data, combinational on a1
// BEHAVIOUR
//  Reset (reset==0 at edge): SR, Cause, EPC = 0; req = 0; epc_out = 0; dout for PRId = PRID_VALUE.
//  SR (12): IM[15:10], EXL[1], IE[0] writable; other bits read 0.
//  Cause (13): BD[31], IP[15:10], ExcCode[6:2]; not mtc0-writable.
//  EPC (14): all 32 bits writable via mtc0. PRId (15): read-only. Other a1 -> dout = 0.
//  IP[15:10] <= hwint every cycle (registered, 1-cycle latency), independent of EXL.
//  int_req = IE & ~EXL & |(hwint & IM); exc_req = ~EXL & (exc_in != 0); req = int_req | exc_req.
//  req combinational, same cycle as inputs; interrupt priority over exception.
//  On req edge: EXL<=1; ExcCode <= int_req ? 0 : exc_in; BD<=bd_in;
//   EPC <= bd_in ? {vpc[31:2],2'b00}-4 : {vpc[31:2],2'b00}.
//  exl_clr edge: EXL<=0 (when req is not high that cycle).
//  Simultaneous: req beats mtc0 (write dropped) and beats exl_clr; exl_clr beats mtc0 to SR.EXL only.
//  mtc0 to EPC while exl_clr: write lands; epc_out reflects it next cycle (no bypass).
//  No state machine beyond EXL: EXL=0 "normal" -> req -> EXL=1 "handler" -> exl_clr -> EXL=0.
//  While EXL=1 no nested req, including exceptions raised in handler (ignored).
//  dout reads pre-edge register values; no write-through bypass.
// CONFIGURATION
//  CP0_TIMER_EN defined: adds Count (reg 9, +1 per cycle, wraps 0xFFFF_FFFF->0) and
//   Compare (reg 11); Count==Compare sets sticky TI, ORed into IP[15]; mtc0 Compare clears TI;
//   mtc0 Count loads value (increment resumes next cycle).
//  Undefined: regs 9/11 read 0, writes ignored, IP[15] = hwint[5] only.
// STRUCTURE
//  cp0_pkg: register numbers (SR=12,CAUSE=13,EPC=14,PRID=15,COUNT=9,COMPARE=11),
//   ExcCode constants (INT=0,ADEL=4,ADES=5,RI=10,OV=12), SR/Cause bit-position localparams.
//  Sub-module cp0_timer (Count/Compare/TI), instantiated only under CP0_TIMER_EN.
// TESTING
//  Reset low 2 cycles, read a1=15 -> dout=PRID_VALUE; a1=12/13/14 -> 0; req=0.
//  mtc0 SR=0x0000_0401, hwint=6'b000001 -> req=1 same cycle; next: EXL=1, ExcCode=0, req=0.
//  exc_in=4, vpc=0x3008, bd_in=1, EXL=0 -> req=1; next EPC=0x3004, Cause=0x8000_0010.
//  EXL=1, exc_in=12 -> req=0, Cause/EPC unchanged; exl_clr -> EXL=0 next cycle.
//  Same cycle we=1 a2=14 din=0x5000 and exc_in=10 -> EPC = vpc, not 0x5000.
//  CP0_TIMER_EN: Compare=5, Count=0, SR=0x8001 -> req at cycle Count==5; mtc0 Compare clears IP[15].

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers, exception codes and SR/Cause bit positions.
// Used by cp0_unit and by the optional timer (CP0_TIMER_EN).
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE_BIT    = 0;
    localparam int SR_EXL_BIT   = 1;
    localparam int SR_IM_LO     = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_BD_BIT = 31;

    function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl, input logic ie);
        logic [31:0] v;
        v = '0;
        v[SR_IM_LO +: 6] = im;
        v[SR_EXL_BIT]    = exl;
        v[SR_IE_BIT]     = ie;
        return v;
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip, input logic [4:0] exc);
        logic [31:0] v;
        v = '0;
        v[CAUSE_BD_BIT]        = bd;
        v[CAUSE_IP_LO +: 6]    = ip;
        v[CAUSE_EXC_LO +: 5]   = exc;
        return v;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with sticky timer-interrupt flag; only built with CP0_TIMER_EN.
// ti is asserted in the same cycle Count matches Compare.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;
    logic        w_match;
    logic        w_wr_count;
    logic        w_wr_compare;

    assign w_match      = (r_count == r_compare);
    assign w_wr_count   = we && (addr == REG_COUNT);
    assign w_wr_compare = we && (addr == REG_COMPARE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            r_count <= w_wr_count ? din : r_count + 32'd1;
            // Writing Compare acknowledges the timer interrupt.
            if (w_wr_compare) begin
                r_compare <= din;
                r_ti      <= 1'b0;
            end else if (w_match) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign count   = r_count;
    assign compare = r_compare;
    assign ti      = r_ti | w_match;

endmodule

// File: rtl/cp0_unit.sv
// CP0 responder beside the M stage: SR/Cause/EPC/PRId, exception/interrupt request, eret EPC.
// Optional Count/Compare timer is enabled by defining CP0_TIMER_EN.
//
// EXL | meaning
// 0   | normal: exceptions and enabled interrupts raise req
// 1   | handler: req suppressed until exl_clr (eret)
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h2021_0007,
    parameter int          HWINT_W    = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         a1,
    input  logic [4:0]         a2,
    input  logic [31:0]        din,
    input  logic               we,
    input  logic [31:0]        vpc,
    input  logic               bd_in,
    input  logic [4:0]         exc_in,
    input  logic               exl_clr,
    input  logic [HWINT_W-1:0] hwint,
    output logic               req,
    output logic [31:0]        epc_out,
    output logic [31:0]        dout
);

    logic [HWINT_W-1:0] r_im;
    logic               r_exl;
    logic               r_ie;
    logic [HWINT_W-1:0] r_ip;
    logic               r_bd;
    logic [4:0]         r_exc;
    logic [31:0]        r_epc;

    logic [HWINT_W-1:0] w_int_lines;
    logic               w_int_req;
    logic               w_exc_req;
    logic               w_req;
    logic               w_wr_en;
    logic [31:0]        w_vpc_aligned;
    logic [31:0]        w_epc_next;

`ifdef CP0_TIMER_EN
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;

    cp0_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .we      (w_wr_en),
        .addr    (a2),
        .din     (din),
        .count   (w_count),
        .compare (w_compare),
        .ti      (w_ti)
    );

    assign w_int_lines = hwint | {w_ti, {(HWINT_W-1){1'b0}}};
`else
    assign w_int_lines = hwint;
`endif

    assign w_int_req     = r_ie & ~r_exl & (|(w_int_lines & r_im));
    assign w_exc_req     = ~r_exl & (exc_in != EXC_INT);
    assign w_req         = w_int_req | w_exc_req;
    // A taken exception squashes the M-stage mtc0.
    assign w_wr_en       = we & ~w_req;
    assign w_vpc_aligned = vpc & ~32'h3;
    assign w_epc_next    = bd_in ? (w_vpc_aligned - 32'd4) : w_vpc_aligned;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_im  <= '0;
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
            r_ip  <= '0;
            r_bd  <= 1'b0;
            r_exc <= EXC_INT;
            r_epc <= '0;
        end else begin
            r_ip <= w_int_lines;
            if (w_req) begin
                r_exl <= 1'b1;
                r_exc <= w_int_req ? EXC_INT : exc_in;
                r_bd  <= bd_in;
                r_epc <= w_epc_next;
            end else begin
                if (w_wr_en && (a2 == REG_SR)) begin
                    r_im  <= din[SR_IM_LO +: HWINT_W];
                    r_exl <= din[SR_EXL_BIT];
                    r_ie  <= din[SR_IE_BIT];
                end
                // eret wins over a same-cycle mtc0 to SR, for EXL only.
                if (exl_clr) begin
                    r_exl <= 1'b0;
                end
                if (w_wr_en && (a2 == REG_EPC)) begin
                    r_epc <= din;
                end
            end
        end
    end

    always_comb begin
        dout = '0;
        case (a1)
            REG_SR:      dout = pack_sr(r_im, r_exl, r_ie);
            REG_CAUSE:   dout = pack_cause(r_bd, r_ip, r_exc);
            REG_EPC:     dout = r_epc;
            REG_PRID:    dout = PRID_VALUE;
`ifdef CP0_TIMER_EN
            REG_COUNT:   dout = w_count;
            REG_COMPARE: dout = w_compare;
`endif
            default:     dout = '0;
        endcase
    end

    assign req     = w_req;
    assign epc_out = r_epc;

endmodule
